// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a show-ahead byte FIFO.
// Single clock domain; rx is brought in through a 2-flop synchroniser.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_DEPTH   = 16,
    parameter int AW           = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rx,
    input  logic          rd_en,
    output logic [7:0]    rd_data,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          frame_err,
    output logic          overrun
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   DEPTH  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_e;

    state_e          state_q, state_d;
    logic            sync1_q, sync1_d;
    logic            rxs_q, rxs_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            frame_err_q, frame_err_d;
    logic            overrun_q, overrun_d;
    logic [7:0]      mem_q [FIFO_DEPTH];

    logic            push_req;
    logic            do_push;
    logic            pop;
    logic            is_full;
    logic            is_empty;

    // Synchroniser stages: pin -> sync1 -> rxs
    always_comb begin
        sync1_d = rx;
        rxs_d   = sync1_q;
    end

    // Receive FSM: bit timing, sampling and frame decision
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        push_req    = 1'b0;
        frame_err_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!rxs_q) begin
                    state_d = S_START;
                    timer_d = '0;
                end
            end
            S_START: begin
                if (timer_q == T_HALF) begin
                    timer_d = '0;
                    if (!rxs_q) begin
                        state_d   = S_DATA;
                        bit_idx_d = 3'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_DATA: begin
                if (timer_q == T_FULL) begin
                    timer_d   = '0;
                    shift_d   = {rxs_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_STOP: begin
                if (timer_q == T_FULL) begin
                    timer_d = '0;
                    if (rxs_q) begin
                        push_req = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_BREAK: begin
                if (rxs_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FIFO control: a pop in the same cycle frees the slot for a push
    always_comb begin
        is_full   = (count_q == DEPTH);
        is_empty  = (count_q == '0);
        pop       = rd_en && !is_empty;
        do_push   = push_req && (!is_full || pop);
        overrun_d = push_req && is_full && !pop;
        wr_ptr_d  = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d   = count_q;
        if (do_push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            sync1_q     <= 1'b1;
            rxs_q       <= 1'b1;
            timer_q     <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            rxs_q       <= rxs_d;
            timer_q     <= timer_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    // Byte storage; contents are don't-care until pushed
    always_ff @(posedge clk) begin
        if (rst_n && do_push) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    // Outputs come from registers only; head reads zero when empty
    always_comb begin
        rd_data   = is_empty ? 8'h00 : mem_q[rd_ptr_q];
        empty     = is_empty;
        full      = is_full;
        count     = count_q;
        frame_err = frame_err_q;
        overrun   = overrun_q;
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive side of the board UART link. Deserialises 8N1 frames arriving on the FPGA's UART input pin (driven by the USB-UART bridge) and buffers the bytes in a small FIFO for the core-side consumer. It complements the existing transmit path so the soft-CPU subsystem can accept host input without polling at bit rate. It runs entirely in the MMCM-derived system clock domain.

## Interface
- CLKS_PER_BIT, 104, system clocks per UART bit (12 MHz / 115200); must be ≥ 4.
- FIFO_DEPTH, 16, byte entries; power of two, ≥ 2.
- AW, 4, log2(FIFO_DEPTH).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- rx  in  1  asynchronous serial input; idle high.
- rd_en  in  1  pop request; ignored when empty.
- rd_data  out  8  FIFO head (show-ahead); valid while empty=0.
- empty  out  1  FIFO holds no bytes.
- full  out  1  FIFO holds FIFO_DEPTH bytes.
- count  out  AW+1  bytes currently held, 0..FIFO_DEPTH.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: byte completed while FIFO full and no pop that cycle.

## Operation
- Reset (rst_n=0 at a clk edge): FSM→IDLE, synchroniser flops→1, bit counter/timer→0, FIFO pointers→0. Outputs: empty=1, full=0, count=0, rd_data=8'h00, frame_err=0, overrun=0.
- rx passes through a 2-flop synchroniser; all decisions use the synchronised signal rxs.
- FSM states:
  - IDLE: on rxs=0 → START, timer=0.
  - START: count to CLKS_PER_BIT/2−1 (integer division); at that point rxs=0 → DATA, timer=0, bit index=0; rxs=1 → IDLE (glitch rejected, nothing recorded).
  - DATA: every CLKS_PER_BIT cycles sample rxs into shift register, LSB first; after bit 7 → STOP.
  - STOP: after CLKS_PER_BIT cycles sample rxs. 1 → push byte (subject to FIFO rule), → IDLE. 0 → frame_err pulse, byte discarded, → BREAK.
  - BREAK: wait for rxs=1, then → IDLE. Holds break/stuck-low lines without spurious frames.
- FIFO: circular buffer, AW-bit read/write pointers wrap modulo FIFO_DEPTH; count tracked separately.
  - Push only (not full): write, count+1.
  - Pop only (not empty): advance read pointer, count−1.
  - Push and pop same cycle: both occur, count unchanged; legal even when full (pop frees the slot) and when count=1.
  - Push while full without pop: byte dropped, overrun pulse, FIFO unchanged.
  - rd_en while empty: no effect.
- frame_err and overrun never assert in the same cycle as each other.

## Timing
- Synchroniser latency: 2 cycles from rx pin to rxs.
- Sample points: data bit n sampled at CLKS_PER_BIT/2 + (n+1)·CLKS_PER_BIT cycles after the IDLE→START edge; stop bit at +9·CLKS_PER_BIT.
- Push occurs on the stop-sample edge; empty falls, count increments, rd_data shows the byte the following cycle.
- rd_data updates the cycle after an rd_en pop; combinational path from rd_en to outputs is not permitted.
- Back-to-back frames: next start bit accepted from the first IDLE cycle after the stop sample (≥ half a stop bit of margin).
- Reset mid-frame: partial byte discarded; FIFO contents cleared; no pulses generated.

## Test plan
- CLKS_PER_BIT=8: send 8'hA5 8N1 → after stop sample empty=0, count=1, rd_data=8'hA5; rd_en one cycle → empty=1, count=0.
- rx low for 3 cycles then high (CLKS_PER_BIT=8) → FSM returns to IDLE, no push, no pulses.
- Frame 8'h3C with stop bit 0, line held low 20 bit times, then valid 8'h5A → one frame_err pulse, FIFO then holds only 8'h5A.
- 17 frames 8'h00..8'h10 with no reads (FIFO_DEPTH=16) → full=1 after 16th, overrun pulse on 17th, reads return 8'h00..8'h0F in order, then empty=1.
- FIFO full, rd_en asserted on the stop-sample cycle of frame 8'hEE → no overrun, count stays 16, 8'hEE read last.
- rst_n=0 during DATA of frame 8'hFF with 3 bytes queued → count=0, empty=1; subsequent frame 8'h81 received correctly.
